// File: rtl/cloclz_gen_pkg.sv
// Shared constants and types for the CLO/CLZ word generator.
package cloclz_gen_pkg;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 6;

    // Largest meaningful run length; larger requests clamp to this value.
    localparam logic [CNT_W-1:0] CNT_SAT = 6'd32;

    // Type encoding shared with the CLO/CLZ counter unit.
    localparam logic TYPE_CLO = 1'b0;
    localparam logic TYPE_CLZ = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Clamp a requested run length to the word width.
    function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] cnt);
        return (cnt > CNT_SAT) ? CNT_SAT : cnt;
    endfunction

endpackage

// File: rtl/cloclz_gen_chunk.sv
// Combinational slice builder: produces one BITS_PER_CYCLE-wide chunk of
// the generated word, MSB first, from the chunk index and run parameters.
module cloclz_gen_chunk
    import cloclz_gen_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 4
) (
    input  logic [CNT_W-1:0]          chunk_idx,
    input  logic [CNT_W-1:0]          run_len,
    input  logic                      run_bit,
    input  logic [BITS_PER_CYCLE-1:0] tail_slice,
    output logic [BITS_PER_CYCLE-1:0] slice
);

    int pos;

    // Slice bit j sits at distance pos from the word MSB; before the run
    // length it is the run bit, at it the terminator, beyond it the tail.
    always_comb begin
        slice = '0;
        pos   = 0;
        for (int j = 0; j < BITS_PER_CYCLE; j++) begin
            pos = int'(chunk_idx) * BITS_PER_CYCLE + (BITS_PER_CYCLE - 1 - j);
            if (pos < int'(run_len)) begin
                slice[j] = run_bit;
            end else if (pos == int'(run_len)) begin
                slice[j] = ~run_bit;
            end else begin
                slice[j] = tail_slice[j];
            end
        end
    end

endmodule

// File: rtl/cloclz_gen.sv
// Iterative generator of a 32-bit word whose CLO (type 0) or CLZ (type 1)
// count equals a requested run length. Builds BITS_PER_CYCLE bits per
// cycle, MSB first.
// Handshake: start is accepted only while busy=0 and flush=0; busy is high
// from the cycle after acceptance until done; done is a one-cycle pulse
// coinciding with the new gen_out, which is held until the next done.
module cloclz_gen
    import cloclz_gen_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [CNT_W-1:0]  cnt_in,
    input  logic              type_in,
    input  logic [DATA_W-1:0] tail_in,
    input  logic              flush,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] gen_out
);

    localparam int B = BITS_PER_CYCLE;
    localparam bit B_OK = (B == 1) || (B == 2) || (B == 4) ||
                          (B == 8) || (B == 16) || (B == 32);
    localparam logic [CNT_W-1:0] K_LAST = CNT_W'(DATA_W / B - 1);

    if (!B_OK) begin : g_bad_bits_per_cycle
        $error("cloclz_gen: BITS_PER_CYCLE must be 1, 2, 4, 8, 16 or 32");
    end

    state_t            state;
    logic [CNT_W-1:0]  k_q;
    logic [CNT_W-1:0]  n_q;
    logic              b_q;
    logic [DATA_W-1:0] tail_q;
    logic [DATA_W-1:0] acc;

    logic [4:0]        chunk_msb;
    logic [B-1:0]      tail_slice;
    logic [B-1:0]      slice;
    logic [DATA_W-1:0] full_word;

    // Select the tail bits covered by the current chunk.
    always_comb begin
        chunk_msb  = 5'(DATA_W - 1 - int'(k_q) * B);
        tail_slice = tail_q[chunk_msb -: B];
    end

    cloclz_gen_chunk #(
        .BITS_PER_CYCLE (B)
    ) u_chunk (
        .chunk_idx  (k_q),
        .run_len    (n_q),
        .run_bit    (b_q),
        .tail_slice (tail_slice),
        .slice      (slice)
    );

    // Accumulator with the current chunk merged in; on the last chunk this
    // is the complete word.
    always_comb begin
        full_word                 = acc;
        full_word[chunk_msb -: B] = slice;
    end

    // Control FSM, operand capture, accumulation and registered outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            k_q     <= '0;
            n_q     <= '0;
            b_q     <= 1'b0;
            tail_q  <= '0;
            acc     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            gen_out <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !flush) begin
                        n_q    <= sat_cnt(cnt_in);
                        b_q    <= ~type_in;
                        tail_q <= tail_in;
                        k_q    <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (flush) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        acc <= full_word;
                        if (k_q == K_LAST) begin
                            gen_out <= full_word;
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            k_q <= k_q + 1'b1;
                        end
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cloclz_gen.sv
// Bench for cloclz_gen: directed scenarios on a 4-bit/cycle instance plus
// random round-trip runs on 1-, 4- and 32-bit/cycle instances.
module tb_cloclz_gen;

    localparam int N_RAND = 1200;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic        start_r;
    logic        flush;
    logic        flush_r;
    logic [5:0]  cnt_in;
    logic        type_in;
    logic [31:0] tail_in;

    logic        busy, done;
    logic [31:0] gen_out;
    logic        busy1, done1;
    logic [31:0] gen1;
    logic        busy32, done32;
    logic [31:0] gen32;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected words and {type, N} metadata, one queue pair per instance.
    logic [31:0] exp_q[$];
    logic [6:0]  meta_q[$];
    logic [31:0] exp1_q[$];
    logic [6:0]  meta1_q[$];
    logic [31:0] exp32_q[$];
    logic [6:0]  meta32_q[$];

    always #5 clk = ~clk;

    cloclz_gen #(.BITS_PER_CYCLE(4)) u_dut (
        .clk (clk), .resetn (resetn), .start (start), .cnt_in (cnt_in),
        .type_in (type_in), .tail_in (tail_in), .flush (flush),
        .busy (busy), .done (done), .gen_out (gen_out)
    );

    cloclz_gen #(.BITS_PER_CYCLE(1)) u_b1 (
        .clk (clk), .resetn (resetn), .start (start_r), .cnt_in (cnt_in),
        .type_in (type_in), .tail_in (tail_in), .flush (flush_r),
        .busy (busy1), .done (done1), .gen_out (gen1)
    );

    cloclz_gen #(.BITS_PER_CYCLE(32)) u_b32 (
        .clk (clk), .resetn (resetn), .start (start_r), .cnt_in (cnt_in),
        .type_in (type_in), .tail_in (tail_in), .flush (flush_r),
        .busy (busy32), .done (done32), .gen_out (gen32)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference word built bit by bit from the run/terminator/tail rule.
    function automatic logic [31:0] model_word(input int n, input logic t, input logic [31:0] tail);
        int ns;
        logic b;
        logic [31:0] w;
        ns = (n > 32) ? 32 : n;
        b  = ~t;
        w  = '0;
        for (int p = 31; p >= 0; p--) begin
            if (31 - p < ns)       w[p] = b;
            else if (31 - p == ns) w[p] = ~b;
            else                   w[p] = tail[p];
        end
        return w;
    endfunction

    // Independent CLO/CLZ counter for the round-trip check.
    function automatic int lead_count(input logic [31:0] w, input logic t);
        int c;
        logic run;
        c   = 0;
        run = 1'b1;
        for (int p = 31; p >= 0; p--) begin
            if (run && (w[p] == ~t)) c++;
            else run = 1'b0;
        end
        return c;
    endfunction

    task automatic push_all(input int n, input logic t, input logic [31:0] tail,
                            input bit main, input bit extra);
        logic [31:0] w;
        logic [6:0]  m;
        w = model_word(n, t, tail);
        m = {t, 6'((n > 32) ? 32 : n)};
        if (main) begin exp_q.push_back(w); meta_q.push_back(m); end
        if (extra) begin
            exp1_q.push_back(w);  meta1_q.push_back(m);
            exp32_q.push_back(w); meta32_q.push_back(m);
        end
    endtask

    // Drive a one-cycle start on the main instance; returns one negedge later.
    task automatic drive_start(input int n, input logic t, input logic [31:0] tail, input bit accept);
        cnt_in  = 6'(n);
        type_in = t;
        tail_in = tail;
        start   = 1'b1;
        if (accept) push_all(n, t, tail, 1'b1, 1'b0);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int w;
        w = 0;
        while (!done && w < budget) begin
            @(negedge clk);
            w++;
        end
        if (!done) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    // Scoreboards: pop on every done pulse and compare word and round trip.
    always @(negedge clk) begin
        if (resetn && done) begin
            if (exp_q.size() == 0) check("b4_unexpected_done", 32'd1, 32'd0);
            else begin
                logic [31:0] ew;
                logic [6:0]  m;
                ew = exp_q.pop_front();
                m  = meta_q.pop_front();
                check("b4_word", gen_out, ew);
                check("b4_roundtrip", 32'(lead_count(gen_out, m[6])), 32'(m[5:0]));
            end
        end
    end

    always @(negedge clk) begin
        if (resetn && done1) begin
            if (exp1_q.size() == 0) check("b1_unexpected_done", 32'd1, 32'd0);
            else begin
                logic [31:0] ew;
                logic [6:0]  m;
                ew = exp1_q.pop_front();
                m  = meta1_q.pop_front();
                check("b1_word", gen1, ew);
                check("b1_roundtrip", 32'(lead_count(gen1, m[6])), 32'(m[5:0]));
            end
        end
    end

    always @(negedge clk) begin
        if (resetn && done32) begin
            if (exp32_q.size() == 0) check("b32_unexpected_done", 32'd1, 32'd0);
            else begin
                logic [31:0] ew;
                logic [6:0]  m;
                ew = exp32_q.pop_front();
                m  = meta32_q.pop_front();
                check("b32_word", gen32, ew);
                check("b32_roundtrip", 32'(lead_count(gen32, m[6])), 32'(m[5:0]));
            end
        end
    end

    initial begin
        bit saw_done;
        resetn  = 1'b0;
        start   = 1'b0;
        start_r = 1'b0;
        flush   = 1'b0;
        flush_r = 1'b0;
        cnt_in  = '0;
        type_in = 1'b0;
        tail_in = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_gen_out", gen_out, 32'h0);
        resetn = 1'b1;
        @(negedge clk);

        // Exact latency: busy for 8 cycles, done on the 8th edge after accept.
        drive_start(5, 1'b0, 32'h0, 1'b1);
        for (int c = 1; c <= 8; c++) begin
            check("t1_busy", 32'(busy), 32'd1);
            check("t1_no_done", 32'(done), 32'd0);
            @(negedge clk);
        end
        check("t1_done", 32'(done), 32'd1);
        check("t1_busy_low", 32'(busy), 32'd0);
        check("t1_word", gen_out, 32'hF800_0000);
        @(negedge clk);
        check("t1_done_pulse", 32'(done), 32'd0);

        // Flush in the third RUN cycle: no done, gen_out held.
        drive_start(9, 1'b1, 32'hA5A5_A5A5, 1'b0);
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_hold", gen_out, 32'hF800_0000);
        saw_done = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (done) saw_done = 1'b1;
            @(negedge clk);
        end
        check("flush_no_done", 32'(saw_done), 32'd0);

        // Flush and start together: start is dropped.
        cnt_in = 6'd4;
        start  = 1'b1;
        flush  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        check("flush_start_busy", 32'(busy), 32'd0);
        repeat (10) @(negedge clk);
        check("flush_start_hold", gen_out, 32'hF800_0000);

        // Back-to-back: restart in the done cycle.
        drive_start(3, 1'b1, 32'hFFFF_FFFF, 1'b1);
        wait_done("b2b_first", 20);
        check("b2b_first_word", gen_out, 32'h1FFF_FFFF);
        drive_start(0, 1'b0, 32'hFFFF_FFFF, 1'b1);
        for (int c = 1; c <= 8; c++) begin
            check("b2b_busy", 32'(busy), 32'd1);
            check("b2b_no_done", 32'(done), 32'd0);
            @(negedge clk);
        end
        check("b2b_second_done", 32'(done), 32'd1);
        check("b2b_second_word", gen_out, 32'h7FFF_FFFF);
        @(negedge clk);

        // Start pulses and input changes while busy are ignored.
        drive_start(32, 1'b0, 32'h1234_5678, 1'b1);
        for (int c = 1; c <= 8; c++) begin
            start   = (c == 3 || c == 5);
            cnt_in  = 6'd1;
            type_in = 1'b1;
            tail_in = 32'h0F0F_0F0F;
            @(negedge clk);
        end
        start = 1'b0;
        check("busy_start_done", 32'(done), 32'd1);
        check("sat32_word", gen_out, 32'hFFFF_FFFF);
        @(negedge clk);
        check("busy_start_idle", 32'(busy), 32'd0);

        // Saturation above 32.
        drive_start(40, 1'b1, 32'hDEAD_BEEF, 1'b1);
        wait_done("sat40", 20);
        check("sat40_word", gen_out, 32'h0000_0000);
        @(negedge clk);

        // Asynchronous reset in mid-RUN.
        drive_start(7, 1'b0, 32'h5555_5555, 1'b0);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_done", 32'(done), 32'd0);
        check("rst_mid_gen_out", gen_out, 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        saw_done = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (done) saw_done = 1'b1;
            @(negedge clk);
        end
        check("rst_mid_no_done", 32'(saw_done), 32'd0);

        // Random round trip on all three instances.
        for (int op = 0; op < N_RAND; op++) begin
            int n;
            logic t;
            logic [31:0] tl;
            bit s4, s1, s32;
            int w;
            n  = $urandom_range(0, 40);
            t  = 1'($urandom_range(0, 1));
            tl = $urandom;
            cnt_in  = 6'(n);
            type_in = t;
            tail_in = tl;
            start   = 1'b1;
            start_r = 1'b1;
            push_all(n, t, tl, 1'b1, 1'b1);
            @(negedge clk);
            start   = 1'b0;
            start_r = 1'b0;
            s4 = 1'b0; s1 = 1'b0; s32 = 1'b0;
            w  = 0;
            while (!(s4 && s1 && s32) && w < 40) begin
                if (done)   s4  = 1'b1;
                if (done1)  s1  = 1'b1;
                if (done32) s32 = 1'b1;
                if (!(s4 && s1 && s32)) begin
                    cnt_in  = 6'($urandom_range(0, 63));
                    type_in = 1'($urandom_range(0, 1));
                    tail_in = $urandom;
                    @(negedge clk);
                    w++;
                end
            end
            if (!(s4 && s1 && s32)) check("rand_timeout", 32'd0, 32'd1);
        end
        @(negedge clk);

        check("b4_queue_empty", 32'(exp_q.size()), 32'd0);
        check("b1_queue_empty", 32'(exp1_q.size()), 32'd0);
        check("b32_queue_empty", 32'(exp32_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
